seq_divider: RTL

Multi-cycle restoring integer divider for the CPU datapath ALU. It executes the DIV opcode (5'b01111) over WIDTH iterations and returns the quotient for the Z low half / LO and the remainder for the Z high half / HI. It supports signed and unsigned operands and a start/done handshake that the control unit sequences against. It also flags divide-by-zero, all parametrised in operand width.

---
 rtl/div_pkg.sv | 21 ++
 rtl/seq_divider_if.sv | 32 +++
 rtl/div_step.sv | 32 +++
 rtl/seq_divider.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the sequential divider slice: FSM state encoding,
//   the ALU opcode this unit serves, and the default operand width.
// ---------------------------------------------------------------------------
package div_pkg;

    // ALU opcode decoded by the control unit to launch this unit.
    localparam logic [4:0] DIV_OPCODE    = 5'b01111;

    // Datapath width used when a parent does not override WIDTH.
    localparam int         DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if
//   Start/done handshake and operand/result bus between the control unit
//   (master) and the divider (slave).
//   master drives : start, is_signed, dividend, divisor
//   slave drives  : busy, done, quotient, remainder, div_by_zero
// ---------------------------------------------------------------------------
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
//   One combinational restoring-division iteration.
//   rem_in   : current partial remainder (always < divisor)
//   msb_in   : next dividend bit shifted into the remainder
//   divisor  : divisor magnitude
//   rem_out  : partial remainder after the trial subtraction
//   q_bit    : quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             msb_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    // The shifted remainder needs one extra bit: rem < divisor < 2^WIDTH,
    // so {rem, msb} < 2^(WIDTH+1).
    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {rem_in, msb_in};
        q_bit   = (shifted >= {1'b0, divisor});
        // When the subtraction succeeds the true difference is < divisor,
        // so a WIDTH-bit wrap-around subtraction gives the exact result.
        rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring integer divider (ALU DIV opcode). Produces the
//   quotient (Z low / LO) and remainder (Z high / HI) after WIDTH iterations
//   plus a sign-fix cycle; flags division by zero.
//   clock : rising-edge clock
//   clear : synchronous active-high reset
//   bus   : seq_divider_if slave (start/operands in, busy/done/results out)
//   Build option: define SEQ_DIV_SIGNED_EN to honour is_signed; otherwise
//   all operands are unsigned (latency is the same in both builds).
// ---------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clock,
    input  logic          clear,
    seq_divider_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] rem_q;       // partial remainder
    logic [WIDTH-1:0] dvd_q;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dsr_q;       // divisor magnitude
    logic             dbz_q;       // current operation is a divide-by-zero
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             flag_q;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             divisor_zero;

    assign divisor_zero = (bus.divisor == '0);

`ifdef SEQ_DIV_SIGNED_EN
    logic sign_a, sign_b;
    logic q_neg_q, r_neg_q;

    assign sign_a = bus.is_signed & bus.dividend[WIDTH-1];
    assign sign_b = bus.is_signed & bus.divisor[WIDTH-1];
    assign mag_a  = sign_a ? -bus.dividend : bus.dividend;
    assign mag_b  = sign_b ? -bus.divisor  : bus.divisor;
    // Truncation toward zero: quotient sign is the XOR of the operand signs,
    // remainder follows the dividend. Most-negative / -1 wraps back to
    // most-negative through the magnitude path with no special casing.
    assign q_fix  = q_neg_q ? -dvd_q : dvd_q;
    assign r_fix  = r_neg_q ? -rem_q : rem_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (state_q == IDLE && bus.start) begin
            q_neg_q <= sign_a ^ sign_b;
            r_neg_q <= sign_a;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = bus.is_signed;
    assign mag_a = bus.dividend;
    assign mag_b = bus.divisor;
    assign q_fix = dvd_q;
    assign r_fix = rem_q;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .msb_in  (dvd_q[WIDTH-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (clear) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
        unique case (state_q)
            IDLE: if (bus.start) begin
                // A zero divisor skips iteration; FIX writes the fixed
                // result so done still comes from the DONE state.
                state_d = divisor_zero ? FIX : RUN;
            end
            RUN:  if (count_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock) begin
        if (clear) begin
            count_q     <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            flag_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.start) begin
                    count_q <= '0;
                    rem_q   <= '0;
                    dsr_q   <= mag_b;
                    dbz_q   <= divisor_zero;
                    // Divide-by-zero returns the dividend untouched.
                    dvd_q   <= divisor_zero ? bus.dividend : mag_a;
                end
                RUN: begin
                    rem_q   <= step_rem;
                    dvd_q   <= {dvd_q[WIDTH-2:0], step_qbit};
                    count_q <= count_q + CNT_W'(1);
                end
                FIX: begin
                    if (dbz_q) begin
                        quotient_q  <= '1;
                        remainder_q <= dvd_q;
                        flag_q      <= 1'b1;
                    end else begin
                        quotient_q  <= q_fix;
                        remainder_q <= r_fix;
                        flag_q      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = flag_q;

endmodule
